i2s_slave_rx: RTL and testbench

I2S_SLAVE_RX -- requirements
Module: i2s_slave_rx

---
 rtl/i2s_slave_rx.sv | 168 ++++++++++++++++
 tb/tb_i2s_slave_rx.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_slave_rx.sv
// Philips I2S receiver: samples the external bit clock domain through synchronizers and emits one word per slot.
// Optional macro I2S_SLAVE_RX_ERR_DETECT_EN adds err_o, flagging slots shorter than WORD_WIDTH.
module i2s_slave_rx #(
  parameter int WORD_WIDTH = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  output logic [WORD_WIDTH-1:0] data_o,
  output logic                  lr_chnl_o,
  output logic                  write_o,
`ifdef I2S_SLAVE_RX_ERR_DETECT_EN
  output logic                  err_o,
`endif
  input  logic                  sclk_i,
  input  logic                  wsel_i,
  input  logic                  sdat_i
);

  localparam int CW = $clog2(WORD_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_e;

  logic [2:0]            sclk_sync_q, sclk_sync_d;
  logic [1:0]            wsel_sync_q, wsel_sync_d;
  logic [1:0]            sdat_sync_q, sdat_sync_d;
  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [WORD_WIDTH-1:0] shift_q, shift_d;
  logic [WORD_WIDTH-1:0] word_q, word_d;
  logic [WORD_WIDTH-1:0] data_q, data_d;
  logic                  chnl_q, chnl_d;
  logic                  word_chnl_q, word_chnl_d;
  logic                  lr_q, lr_d;
  logic                  wsel_prev_q, wsel_prev_d;
  logic                  primed_q, primed_d;
  logic                  emit_q, emit_d;
  logic                  write_q, write_d;
`ifdef I2S_SLAVE_RX_ERR_DETECT_EN
  logic                  short_q, short_d;
  logic                  err_q, err_d;
`endif

  logic                  sclk_rise;
  logic                  wsel_s;
  logic                  sdat_s;
  logic                  wsel_chg;
  logic [WORD_WIDTH-1:0] shifted;
  logic [CW-1:0]         cnt_inc;
  logic [CW-1:0]         pad;

  always_comb begin
    sclk_sync_d = {sclk_sync_q[1:0], sclk_i};
    wsel_sync_d = {wsel_sync_q[0], wsel_i};
    sdat_sync_d = {sdat_sync_q[0], sdat_i};
  end

  assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign wsel_s    = wsel_sync_q[1];
  assign sdat_s    = sdat_sync_q[1];
  // The first edge after reset only records wsel, so a mid-slot release is not mistaken for a change.
  assign wsel_chg  = primed_q & (wsel_s ^ wsel_prev_q);
  assign shifted   = {shift_q[WORD_WIDTH-2:0], sdat_s};
  assign cnt_inc   = cnt_q + CW'(1);
  assign pad       = CW'(WORD_WIDTH) - cnt_inc;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    chnl_d      = chnl_q;
    wsel_prev_d = wsel_prev_q;
    primed_d    = primed_q;
    emit_d      = 1'b0;
    word_d      = word_q;
    word_chnl_d = word_chnl_q;
`ifdef I2S_SLAVE_RX_ERR_DETECT_EN
    short_d     = 1'b0;
`endif
    if (sclk_rise) begin
      wsel_prev_d = wsel_s;
      primed_d    = 1'b1;
      if (wsel_chg) begin
        // The change edge still carries the final bit of the slot being closed.
        if (state_q == SHIFT) begin
          emit_d      = 1'b1;
          word_d      = shifted << pad;
          word_chnl_d = chnl_q;
`ifdef I2S_SLAVE_RX_ERR_DETECT_EN
          short_d     = (cnt_inc != CW'(WORD_WIDTH));
`endif
        end
        state_d = SHIFT;
        cnt_d   = '0;
        chnl_d  = wsel_s;
      end else if (state_q == SHIFT) begin
        shift_d = shifted;
        cnt_d   = cnt_inc;
        if (cnt_inc == CW'(WORD_WIDTH)) begin
          emit_d      = 1'b1;
          word_d      = shifted;
          word_chnl_d = chnl_q;
          state_d     = HOLD;
        end
      end
    end
  end

  always_comb begin
    write_d = emit_q;
    data_d  = emit_q ? word_q : data_q;
    lr_d    = emit_q ? word_chnl_q : lr_q;
`ifdef I2S_SLAVE_RX_ERR_DETECT_EN
    err_d   = emit_q & short_q;
`endif
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sclk_sync_q <= '0;
      wsel_sync_q <= '0;
      sdat_sync_q <= '0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      word_q      <= '0;
      data_q      <= '0;
      chnl_q      <= 1'b0;
      word_chnl_q <= 1'b0;
      lr_q        <= 1'b0;
      wsel_prev_q <= 1'b0;
      primed_q    <= 1'b0;
      emit_q      <= 1'b0;
      write_q     <= 1'b0;
`ifdef I2S_SLAVE_RX_ERR_DETECT_EN
      short_q     <= 1'b0;
      err_q       <= 1'b0;
`endif
    end else begin
      sclk_sync_q <= sclk_sync_d;
      wsel_sync_q <= wsel_sync_d;
      sdat_sync_q <= sdat_sync_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      word_q      <= word_d;
      data_q      <= data_d;
      chnl_q      <= chnl_d;
      word_chnl_q <= word_chnl_d;
      lr_q        <= lr_d;
      wsel_prev_q <= wsel_prev_d;
      primed_q    <= primed_d;
      emit_q      <= emit_d;
      write_q     <= write_d;
`ifdef I2S_SLAVE_RX_ERR_DETECT_EN
      short_q     <= short_d;
      err_q       <= err_d;
`endif
    end
  end

  assign data_o    = data_q;
  assign lr_chnl_o = lr_q;
  assign write_o   = write_q;
`ifdef I2S_SLAVE_RX_ERR_DETECT_EN
  assign err_o     = err_q;
`endif

endmodule

// File: tb/tb_i2s_slave_rx.sv
// Bench for i2s_slave_rx: drives I2S edge streams and checks emitted words against a slot-level model.
module tb_i2s_slave_rx;

  localparam int W = 16;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         sclk_i = 1'b0;
  logic         wsel_i = 1'b0;
  logic         sdat_i = 1'b0;
  logic [W-1:0] data_o;
  logic         lr_chnl_o;
  logic         write_o;
`ifdef I2S_SLAVE_RX_ERR_DETECT_EN
  logic         err_o;
`endif

  int     checks = 0;
  int     failures = 0;
  longint cyc = 0;

  i2s_slave_rx #(.WORD_WIDTH(W)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .data_o    (data_o),
    .lr_chnl_o (lr_chnl_o),
    .write_o   (write_o),
`ifdef I2S_SLAVE_RX_ERR_DETECT_EN
    .err_o     (err_o),
`endif
    .sclk_i    (sclk_i),
    .wsel_i    (wsel_i),
    .sdat_i    (sdat_i)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] data;
    logic         lr;
    logic         err;
    longint       cyc;
  } wr_t;

  typedef struct {
    bit ws;
    bit sd;
  } edge_t;

  wr_t    cap[$];
  wr_t    expq[$];
  edge_t  edges[$];
  longint rise_cyc[$];
  int     sent = 0;

  // Every cycle with write_o high becomes one captured emission; a stretched pulse shows up as an extra entry.
  always @(negedge clk_i) begin
    wr_t w;
    if (write_o === 1'b1) begin
      w.data = data_o;
      w.lr   = lr_chnl_o;
`ifdef I2S_SLAVE_RX_ERR_DETECT_EN
      w.err  = err_o;
`else
      w.err  = 1'b0;
`endif
      w.cyc  = cyc;
      cap.push_back(w);
    end
  end

  // Slot-level reference: a slot runs from one wsel change to the next; the word is the first W bits after the change.
  bit m_primed, m_prev, m_done, m_ch;
  int m_start;

  task automatic model_reset();
    m_primed = 1'b0;
    m_prev   = 1'b0;
    m_done   = 1'b1;
    m_ch     = 1'b0;
    m_start  = 0;
  endtask

  task automatic model_emit(int last);
    wr_t w;
    int  n;
    n = last - m_start;
    w.data = '0;
    for (int k = 0; k < n && k < W; k++) w.data[W-1-k] = edges[m_start+1+k].sd;
    w.lr  = m_ch;
    w.err = (n < W);
    w.cyc = rise_cyc[last] + 4;
    expq.push_back(w);
  endtask

  task automatic model_feed(int i);
    bit ws;
    ws = edges[i].ws;
    if (m_primed && ws != m_prev) begin
      if (!m_done) model_emit(i);
      m_start = i;
      m_ch    = ws;
      m_done  = 1'b0;
    end else if (!m_done && (i - m_start) == W) begin
      model_emit(i);
      m_done = 1'b1;
    end
    m_prev   = ws;
    m_primed = 1'b1;
  endtask

  function automatic bit rb();
    return bit'($urandom_range(0, 1));
  endfunction

  task automatic push(bit ws, bit sd);
    edge_t e;
    e.ws = ws;
    e.sd = sd;
    edges.push_back(e);
  endtask

  // Philips framing: the slot's LSB travels on the edge where wsel already shows the next channel.
  task automatic push_slot(bit ch, int len, logic [31:0] val, bit nxt);
    logic [31:0] v;
    v = val;
    for (int b = len - 1; b >= 1; b--) push(ch, v[b]);
    push(nxt, v[0]);
  endtask

  task automatic lead_in(bit ch);
    push(!ch, rb());
    push(!ch, rb());
    push(ch, rb());
  endtask

  task automatic checkOutput(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change on the sclk falling edge and are held 200 ns either side of the rising edge.
  task automatic applyStimulus();
    while (sent < edges.size()) begin
      wsel_i = edges[sent].ws;
      sdat_i = edges[sent].sd;
      #200;
      sclk_i = 1'b1;
      rise_cyc.push_back(cyc);
      model_feed(sent);
      #200;
      sclk_i = 1'b0;
      sent++;
    end
  endtask

  task automatic do_reset(string tag);
    rst_i = 1'b1;
    model_reset();
    #30;
    checkOutput({tag, "_rst_write"}, 64'(write_o), 64'd0);
    checkOutput({tag, "_rst_data"}, 64'(data_o), 64'd0);
    checkOutput({tag, "_rst_lr"}, 64'(lr_chnl_o), 64'd0);
    rst_i = 1'b0;
    #50;
  endtask

  task automatic begin_scenario(string tag);
    cap.delete();
    expq.delete();
    do_reset(tag);
  endtask

  task automatic compare(string tag);
    int n;
    #200;
    checkOutput({tag, "_count"}, 64'(cap.size()), 64'(expq.size()));
    n = (cap.size() < expq.size()) ? cap.size() : expq.size();
    for (int i = 0; i < n; i++) begin
      checkOutput($sformatf("%s_data%0d", tag, i), 64'(cap[i].data), 64'(expq[i].data));
      checkOutput($sformatf("%s_lr%0d", tag, i), 64'(cap[i].lr), 64'(expq[i].lr));
      checkOutput($sformatf("%s_cyc%0d", tag, i), 64'(cap[i].cyc), 64'(expq[i].cyc));
`ifdef I2S_SLAVE_RX_ERR_DETECT_EN
      checkOutput($sformatf("%s_err%0d", tag, i), 64'(cap[i].err), 64'(expq[i].err));
`endif
    end
    if (expq.size() > 0) begin
      checkOutput({tag, "_hold_data"}, 64'(data_o), 64'(expq[expq.size()-1].data));
      checkOutput({tag, "_hold_lr"}, 64'(lr_chnl_o), 64'(expq[expq.size()-1].lr));
    end
  endtask

  function automatic wr_t cap_at(int i);
    wr_t w;
    w.data = 'x;
    w.lr   = 1'bx;
    w.err  = 1'bx;
    w.cyc  = -1;
    if (i < cap.size()) w = cap[i];
    return w;
  endfunction

  initial begin
    logic [31:0] val;
    bit          ch;
    int          len;

    $display("[TB] reset with toggling I2S inputs");
    model_reset();
    repeat (5) begin
      @(negedge clk_i);
      checkOutput("por_data", 64'(data_o), 64'd0);
      checkOutput("por_lr", 64'(lr_chnl_o), 64'd0);
      checkOutput("por_write", 64'(write_o), 64'd0);
      sclk_i = rb();
      wsel_i = rb();
      sdat_i = rb();
    end
    sclk_i = 1'b0;
    wsel_i = 1'b0;
    sdat_i = 1'b0;
    #3;
    rst_i = 1'b0;
    #40;

    $display("[TB] basic 16-bit frame");
    begin_scenario("basic");
    lead_in(1'b0);
    push_slot(1'b0, 16, 32'hA5C3, 1'b1);
    push_slot(1'b1, 16, 32'h1234, 1'b0);
    push(1'b0, rb());
    push(1'b0, rb());
    applyStimulus();
    compare("basic");
    checkOutput("basic_n", 64'(cap.size()), 64'd2);
    checkOutput("basic_left_data", 64'(cap_at(0).data), 64'hA5C3);
    checkOutput("basic_left_lr", 64'(cap_at(0).lr), 64'd0);
    checkOutput("basic_right_data", 64'(cap_at(1).data), 64'h1234);
    checkOutput("basic_right_lr", 64'(cap_at(1).lr), 64'd1);

    $display("[TB] long 24-bit slot");
    begin_scenario("long");
    lead_in(1'b0);
    push_slot(1'b0, 24, 32'hABCDEF, 1'b1);
    push(1'b1, rb());
    push(1'b1, rb());
    applyStimulus();
    compare("long");
    checkOutput("long_n", 64'(cap.size()), 64'd1);
    checkOutput("long_data", 64'(cap_at(0).data), 64'hABCD);
    checkOutput("long_lr", 64'(cap_at(0).lr), 64'd0);
`ifdef I2S_SLAVE_RX_ERR_DETECT_EN
    checkOutput("long_err", 64'(cap_at(0).err), 64'd0);
`endif

    $display("[TB] short 12-bit slot");
    begin_scenario("short");
    lead_in(1'b1);
    push_slot(1'b1, 12, 32'hFFF, 1'b0);
    push(1'b0, rb());
    push(1'b0, rb());
    applyStimulus();
    compare("short");
    checkOutput("short_n", 64'(cap.size()), 64'd1);
    checkOutput("short_data", 64'(cap_at(0).data), 64'hFFF0);
    checkOutput("short_lr", 64'(cap_at(0).lr), 64'd1);
`ifdef I2S_SLAVE_RX_ERR_DETECT_EN
    checkOutput("short_err", 64'(cap_at(0).err), 64'd1);
`endif

    $display("[TB] unsynchronized stream and mid-word reset");
    begin_scenario("resync");
    push(1'b1, rb());
    push(1'b1, rb());
    push(1'b1, rb());
    push(1'b0, rb());
    repeat (5) push(1'b0, rb());
    applyStimulus();
    #100;
    checkOutput("resync_seg1_nowrite", 64'(cap.size()), 64'd0);
    do_reset("resync_mid");
    repeat (4) push(1'b0, rb());
    push(1'b1, rb());
    val = 32'($urandom_range(0, 16'hFFFF));
    push_slot(1'b1, 16, val, 1'b0);
    push(1'b0, rb());
    push(1'b0, rb());
    applyStimulus();
    compare("resync");
    checkOutput("resync_n", 64'(cap.size()), 64'd1);
    checkOutput("resync_lr", 64'(cap_at(0).lr), 64'd1);
    checkOutput("resync_data", 64'(cap_at(0).data), 64'(val[15:0]));

    for (int it = 0; it < 3; it++) begin
      $display("[TB] random frame %0d", it);
      begin_scenario($sformatf("rand%0d", it));
      ch = rb();
      lead_in(ch);
      for (int s = 0; s < 4; s++) begin
        len = (it == 0 && s == 0) ? 1 : $urandom_range(8, 24);
        val = $urandom;
        push_slot(ch, len, val, !ch);
        ch = !ch;
      end
      push(ch, rb());
      push(ch, rb());
      applyStimulus();
      compare($sformatf("rand%0d", it));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
